// File: rtl/change_dispenser_pkg.sv
// Shared types for the change dispenser: FSM states, coin denomination codes and values.
package change_disp_pkg;

  localparam int unsigned AMT_W   = 32;
  localparam int unsigned DENOM_W = 2;

  localparam int unsigned DENOM_1  = 1;
  localparam int unsigned DENOM_5  = 5;
  localparam int unsigned DENOM_10 = 10;
  localparam int unsigned DENOM_20 = 20;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_DISPENSE = 3'd2,
    ST_DONE     = 3'd3,
    ST_FAULT    = 3'd4
  } state_e;

  typedef enum logic [DENOM_W-1:0] {
    CODE_1  = 2'd0,
    CODE_5  = 2'd1,
    CODE_10 = 2'd2,
    CODE_20 = 2'd3
  } denom_e;

  // Yuan value of a denomination code, sized to the amount datapath.
  function automatic logic [AMT_W-1:0] denom_value(input denom_e code);
    logic [AMT_W-1:0] v;
    v = AMT_W'(DENOM_1);
    case (code)
      CODE_1:  v = AMT_W'(DENOM_1);
      CODE_5:  v = AMT_W'(DENOM_5);
      CODE_10: v = AMT_W'(DENOM_10);
      CODE_20: v = AMT_W'(DENOM_20);
      default: v = AMT_W'(DENOM_1);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Controller/hopper-facing signal bundle of the change dispenser.
interface change_dispenser_if
  import change_disp_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) ();

  logic             start;
  logic [AMT_W-1:0] change_in;
  logic             coin_ack;
  logic             coin_valid;
  denom_e           coin_denom;
  logic             busy;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] remaining;
  logic [CNT_W-1:0] coins_out;

  modport master (
    output start, change_in, coin_ack,
    input  coin_valid, coin_denom, busy, done, fault, remaining, coins_out
  );

  modport slave (
    input  start, change_in, coin_ack,
    output coin_valid, coin_denom, busy, done, fault, remaining, coins_out
  );

endinterface

// File: rtl/change_dispenser_denom_select.sv
// Greedy coin picker: largest denomination not exceeding the amount (1 yuan when below 5).
module denom_select
  import change_disp_pkg::*;
(
  input  logic [AMT_W-1:0] i_amount,
  output denom_e           o_code_c
);

  always_comb begin
    o_code_c = CODE_1;
    if (i_amount >= AMT_W'(DENOM_20)) begin
      o_code_c = CODE_20;
    end else if (i_amount >= AMT_W'(DENOM_10)) begin
      o_code_c = CODE_10;
    end else if (i_amount >= AMT_W'(DENOM_5)) begin
      o_code_c = CODE_5;
    end else begin
      o_code_c = CODE_1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a latched change amount as greedy coins over a valid/ack hopper handshake.
// Optional macro CHANGE_DISP_NEG_CHECK_EN: amounts with bit 31 set fault immediately.
module change_dispenser
  import change_disp_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 1000,
  parameter int unsigned CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  change_dispenser_if.slave bus
);

  localparam int unsigned      WAIT_W    = $clog2(ACK_TIMEOUT);
  // Last counter value seen in DISPENSE before the counter would reach ACK_TIMEOUT-1.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 2);

  state_e            r_state;
  logic [AMT_W-1:0]  r_remaining;
  logic [CNT_W-1:0]  r_coins;
  denom_e            r_denom;
  logic [WAIT_W-1:0] r_wait;
  logic              r_coin_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_fault;

  denom_e            w_sel_code;
  logic              w_neg_amt;

  denom_select u_denom_select (
    .i_amount (r_remaining),
    .o_code_c (w_sel_code)
  );

`ifdef CHANGE_DISP_NEG_CHECK_EN
  assign w_neg_amt = bus.change_in[AMT_W-1];
`else
  assign w_neg_amt = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_remaining  <= '0;
      r_coins      <= '0;
      r_denom      <= CODE_1;
      r_wait       <= '0;
      r_coin_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_busy  <= 1'b1;
            r_coins <= '0;
            if (w_neg_amt) begin
              r_remaining <= '0;
              r_fault     <= 1'b1;
              r_state     <= ST_FAULT;
            end else begin
              r_remaining <= bus.change_in;
              r_state     <= ST_SELECT;
            end
          end
        end

        ST_SELECT: begin
          if (r_remaining == '0) begin
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_denom      <= w_sel_code;
            r_wait       <= '0;
            r_coin_valid <= 1'b1;
            r_state      <= ST_DISPENSE;
          end
        end

        // Ack is checked before the timeout so a late ack still counts the coin.
        ST_DISPENSE: begin
          if (bus.coin_ack) begin
            r_coin_valid <= 1'b0;
            r_remaining  <= r_remaining - denom_value(r_denom);
            if (r_coins != '1) begin
              r_coins <= r_coins + CNT_W'(1);
            end
            r_state <= ST_SELECT;
          end else if (r_wait == WAIT_LAST) begin
            r_coin_valid <= 1'b0;
            r_fault      <= 1'b1;
            r_state      <= ST_FAULT;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end

        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        ST_FAULT: begin
          r_state <= ST_FAULT;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.coin_valid = r_coin_valid;
  assign bus.coin_denom = r_denom;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.fault      = r_fault;
  assign bus.remaining  = r_remaining;
  assign bus.coins_out  = r_coins;

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: table-driven payouts with a coin scoreboard plus corner sequences.
`timescale 1ns/1ps
module tb_change_dispenser;
  import change_disp_pkg::*;

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ACK_TO = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  change_dispenser_if #(.CNT_W(CNT_W)) bus ();

  change_dispenser #(.ACK_TIMEOUT(ACK_TO), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] amt;
    int          delay;
    int          exp_coins;
    int          exp_done;
  } vec_t;

  vec_t        vecs[7];
  logic [1:0]  exp_q[$];
  int          n_pass;
  int          n_total;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference greedy split computed by division, queued in payout order.
  task automatic push_expected(input logic [31:0] amt);
    int unsigned r, n20, n10, n5, n1;
    r   = amt;
    n20 = r / 20; r = r % 20;
    n10 = r / 10; r = r % 10;
    n5  = r / 5;
    n1  = r % 5;
    repeat (n20) exp_q.push_back(2'd3);
    repeat (n10) exp_q.push_back(2'd2);
    repeat (n5)  exp_q.push_back(2'd1);
    repeat (n1)  exp_q.push_back(2'd0);
  endtask

  task automatic run_payout(input string tag, input logic [31:0] amt, input int delay,
                            input int exp_coins, input int exp_done);
    int         cyc, waitc, done_cyc;
    logic       in_coin;
    logic [1:0] held;
    exp_q.delete();
    push_expected(amt);
    bus.start     = 1'b1;
    bus.change_in = amt;
    bus.coin_ack  = (delay == 0);
    cyc = 0; waitc = 0; done_cyc = -1; in_coin = 1'b0; held = 2'd0;
    while (cyc < 200 && done_cyc < 0) begin
      step();
      cyc++;
      bus.start = 1'b0;
      if (bus.done) begin
        done_cyc = cyc;
      end else if (bus.coin_valid) begin
        if (!in_coin) begin
          in_coin = 1'b1;
          held    = bus.coin_denom;
        end else begin
          chk({tag, "_denom_stable"}, 32'(bus.coin_denom), 32'(held));
        end
        if (waitc >= delay) begin
          bus.coin_ack = 1'b1;
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s_extra_coin: got denom code %0d expected no coin", tag, bus.coin_denom);
          end else begin
            chk({tag, "_coin"}, 32'(bus.coin_denom), 32'(exp_q.pop_front()));
          end
          in_coin = 1'b0;
          waitc   = 0;
        end else begin
          bus.coin_ack = 1'b0;
          waitc++;
        end
      end else begin
        bus.coin_ack = (delay == 0);
      end
    end
    chk({tag, "_done_cycle"}, 32'(done_cyc), 32'(exp_done));
    chk({tag, "_coins_out"}, 32'(bus.coins_out), 32'(exp_coins));
    chk({tag, "_remaining"}, bus.remaining, 32'd0);
    chk({tag, "_coins_left"}, 32'(exp_q.size()), 32'd0);
    bus.coin_ack = 1'b0;
    step();
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    vecs[0] = '{32'd0,  0, 0, 2};
    vecs[1] = '{32'd26, 0, 3, 8};
    vecs[2] = '{32'd38, 3, 6, 32};
    vecs[3] = '{32'd4,  1, 4, 14};
    vecs[4] = '{32'd19, 0, 6, 14};
    vecs[5] = '{32'd45, 2, 3, 14};
    vecs[6] = '{32'd5,  0, 1, 4};

    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.change_in = '0;
    bus.coin_ack  = 1'b0;
    repeat (2) step();
    chk("rst_valid",     32'(bus.coin_valid), 32'd0);
    chk("rst_denom",     32'(bus.coin_denom), 32'd0);
    chk("rst_busy",      32'(bus.busy),       32'd0);
    chk("rst_done",      32'(bus.done),       32'd0);
    chk("rst_fault",     32'(bus.fault),      32'd0);
    chk("rst_remaining", bus.remaining,       32'd0);
    chk("rst_coins",     32'(bus.coins_out),  32'd0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 7; i++) begin
      run_payout($sformatf("vec%0d_amt%0d", i, vecs[i].amt), vecs[i].amt, vecs[i].delay,
                 vecs[i].exp_coins, vecs[i].exp_done);
    end

    // Hopper never acks: fault after 7 DISPENSE cycles, then frozen.
    bus.start = 1'b1; bus.change_in = 32'd15; bus.coin_ack = 1'b0;
    step();
    bus.start = 1'b0;
    chk("to_select_valid", 32'(bus.coin_valid), 32'd0);
    repeat (7) step();
    chk("to_last_valid", 32'(bus.coin_valid), 32'd1);
    chk("to_last_fault", 32'(bus.fault),      32'd0);
    chk("to_last_denom", 32'(bus.coin_denom), 32'd2);
    step();
    chk("to_fault",     32'(bus.fault),      32'd1);
    chk("to_valid",     32'(bus.coin_valid), 32'd0);
    chk("to_busy",      32'(bus.busy),       32'd1);
    chk("to_remaining", bus.remaining,       32'd15);
    chk("to_coins",     32'(bus.coins_out),  32'd0);
    bus.start = 1'b1; bus.change_in = 32'd5;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    chk("to_hold_fault",     32'(bus.fault),      32'd1);
    chk("to_hold_remaining", bus.remaining,       32'd15);
    chk("to_hold_valid",     32'(bus.coin_valid), 32'd0);
    chk("to_hold_busy",      32'(bus.busy),       32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("to_cleared_fault", 32'(bus.fault), 32'd0);

    // Ack arriving in the cycle the timeout would fire is accepted.
    bus.start = 1'b1; bus.change_in = 32'd15; bus.coin_ack = 1'b0;
    step();
    bus.start = 1'b0;
    repeat (7) step();
    chk("aw_valid", 32'(bus.coin_valid), 32'd1);
    bus.coin_ack = 1'b1;
    step();
    chk("aw_fault",     32'(bus.fault),      32'd0);
    chk("aw_remaining", bus.remaining,       32'd5);
    chk("aw_coins",     32'(bus.coins_out),  32'd1);
    chk("aw_busy",      32'(bus.busy),       32'd1);
    repeat (3) step();
    chk("aw_done",      32'(bus.done),       32'd1);
    chk("aw_done_coins", 32'(bus.coins_out), 32'd2);
    chk("aw_done_rem",  bus.remaining,       32'd0);
    bus.coin_ack = 1'b0;
    step();

    // Asynchronous reset during the second coin.
    bus.start = 1'b1; bus.change_in = 32'd50; bus.coin_ack = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    chk("mr_valid",     32'(bus.coin_valid), 32'd1);
    chk("mr_coins",     32'(bus.coins_out),  32'd1);
    chk("mr_remaining", bus.remaining,       32'd30);
    #2 rst = 1'b1;
    #1;
    chk("mr_rst_valid",     32'(bus.coin_valid), 32'd0);
    chk("mr_rst_denom",     32'(bus.coin_denom), 32'd0);
    chk("mr_rst_busy",      32'(bus.busy),       32'd0);
    chk("mr_rst_fault",     32'(bus.fault),      32'd0);
    chk("mr_rst_remaining", bus.remaining,       32'd0);
    chk("mr_rst_coins",     32'(bus.coins_out),  32'd0);
    bus.coin_ack = 1'b0;
    step();
    rst = 1'b0;
    step();
    run_payout("mr_after", 32'd5, 0, 1, 4);

    // Amount with bit 31 set.
    bus.start = 1'b1; bus.change_in = 32'hFFFF_FFFE; bus.coin_ack = 1'b0;
    step();
    bus.start = 1'b0;
`ifdef CHANGE_DISP_NEG_CHECK_EN
    chk("neg_fault",     32'(bus.fault),      32'd1);
    chk("neg_busy",      32'(bus.busy),       32'd1);
    chk("neg_valid",     32'(bus.coin_valid), 32'd0);
    chk("neg_remaining", bus.remaining,       32'd0);
    chk("neg_coins",     32'(bus.coins_out),  32'd0);
    step();
    chk("neg_valid_later", 32'(bus.coin_valid), 32'd0);
`else
    chk("big_fault",  32'(bus.fault),      32'd0);
    chk("big_busy",   32'(bus.busy),       32'd1);
    chk("big_select", 32'(bus.coin_valid), 32'd0);
    step();
    chk("big_valid",     32'(bus.coin_valid), 32'd1);
    chk("big_denom",     32'(bus.coin_denom), 32'd3);
    chk("big_remaining", bus.remaining,       32'hFFFF_FFFE);
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Payout stage directly downstream of the change computation. On a start pulse it latches the 32-bit change amount and pays it out as a sequence of coins: greedy, largest denomination first. Each coin is handed to the coin hopper through a valid/ack handshake. It reports progress, completion and hopper faults to the top-level sales controller.

## Interface
Parameters:
- `ACK_TIMEOUT`, default 1000: maximum number of cycles to wait for `coin_ack` per coin before faulting; must be ≥ 2.
- `CNT_W`, default 16: width of the dispensed-coin counter.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `change_in`  in  32  change amount in yuan, unsigned; sampled with `start`.
- `coin_ack`  in  1  hopper accepted the current coin.
- `coin_valid`  out  1  a coin request is presented.
- `coin_denom`  out  2  denomination code: 0=1, 1=5, 2=10, 3=20 yuan.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the payout completes.
- `fault`  out  1  sticky flag for a hopper timeout or an invalid amount.
- `remaining`  out  32  amount still to be paid.
- `coins_out`  out  CNT_W  coins dispensed in the current payout.

## Operation
States: IDLE, SELECT, DISPENSE, DONE, FAULT.
- IDLE
  - `start`=1 → `remaining`←`change_in`, `coins_out`←0, go to SELECT.
  - `start` in any other state is ignored.
- SELECT (exactly 1 cycle)
  - `remaining`==0 → go to DONE.
  - Otherwise register `coin_denom` = the largest value among 20/10/5/1 that is ≤ `remaining`, clear the wait counter, go to DISPENSE.
- DISPENSE
  - `coin_valid`=1; `coin_denom` is held stable.
  - `coin_ack`=1 → `remaining` -= denomination value, `coins_out`+=1 (saturating at all-ones), go to SELECT.
  - Otherwise the wait counter increments. If it reaches `ACK_TIMEOUT`-1 without an ack, go to FAULT.
- DONE: `done`=1 for this single cycle, then go to IDLE.
- FAULT: `fault`=1 and `busy`=1 are held until `rst`. `remaining` freezes at its last value.
- `coin_ack` outside DISPENSE is ignored.
- Arithmetic: the subtraction cannot underflow, because the selected denomination is always ≤ `remaining`.

## Timing
- Reset values: every output is 0 and the FSM is in IDLE. Reset mid-payout drops `coin_valid` immediately and asynchronously; no partial coin is counted.
- Latency for `change_in`=0: `start` in cycle 0, SELECT in cycle 1, `done` in cycle 2, IDLE in cycle 3.
- With the hopper acking in the first DISPENSE cycle, each coin costs 2 cycles (SELECT + DISPENSE). An N-coin payout gives `done` at cycle 2N+2.
- `coin_valid` is registered and rises in the cycle after SELECT.
- Ack on the same cycle the timeout would fire: the ack wins.

## Configuration
- `CHANGE_DISP_NEG_CHECK_EN`
  - Defined: a `change_in` with bit 31 set at `start` is treated as a negative result from the change computation. The block goes directly IDLE→FAULT, with no coins, `remaining`=0 and `coins_out`=0.
  - Undefined: `change_in` is treated as fully unsigned and paid out as-is.

## Structure
- Package `change_disp_pkg` holds:
  - the state enum;
  - the 2-bit denomination codes;
  - constants `DENOM_1`=1, `DENOM_5`=5, `DENOM_10`=10, `DENOM_20`=20;
  - a function mapping code → value.
- One sub-module, `denom_select`: a combinational priority picker taking a 32-bit amount and returning a 2-bit code. It is instantiated once and feeds the SELECT register.

## Test plan
- `change_in`=0, start → no `coin_valid`, `done` at cycle 2, `coins_out`=0.
- `change_in`=26, ack held high → coins 20, 5, 1 in order, `coins_out`=3, `remaining`=0, `done` at cycle 8.
- `change_in`=38, ack delayed 3 cycles per coin → sequence 20, 10, 5, 1, 1, 1; `coin_denom` stable while waiting; `coins_out`=6.
- `ACK_TIMEOUT`=8, `change_in`=15, no ack → FAULT after 7 DISPENSE cycles, `fault`=1, `remaining`=15, a later `start` is ignored.
- Macro defined, `change_in`=32'hFFFF_FFFE → `fault`=1 the cycle after start, no `coin_valid`.
- `change_in`=50, `rst` asserted during the second DISPENSE → all outputs 0 at once; a new start with 5 yields a single 5-yuan coin.
